// File: rtl/ap_divmod.sv
// ap_divmod: iterative radix-2 restoring integer divider with quotient,
// remainder and divide-by-zero flag. Operands load on every rst edge, one
// quotient bit is produced per clock, and ready holds the result until the
// next rst.
module ap_divmod #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
    output logic             dbz,
    output logic             ready
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        FIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Magnitudes are plain unsigned WIDTH-bit values so |MIN| fits exactly.
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] divisor;
    logic [CW-1:0]    count;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             keep;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] a_back;

    // Operand conditioning, one restoring step and the final sign fix-up.
    always_comb begin
        a_neg    = (SIGNED != 0) && a[WIDTH-1];
        b_neg    = (SIGNED != 0) && b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        shifted  = {part_rem, dq[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        keep     = ~trial[WIDTH];
        quot_fix = neg_q ? -dq : dq;
        rem_fix  = neg_r ? -part_rem : part_rem;
        a_back   = neg_r ? -dq : dq;
    end

    // State register; rst always restarts in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: zero divisor skips the iteration entirely.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (div_zero) begin
                    state_next = DONE;
                end else if (count == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    // Datapath and registered outputs; dq holds the unused dividend bits
    // at its top and accumulates quotient bits from the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready    <= 1'b0;
            dbz      <= 1'b0;
            result   <= '0;
            rem      <= '0;
            part_rem <= '0;
            dq       <= a_mag;
            divisor  <= b_mag;
            count    <= '0;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (b == '0);
        end else begin
            case (state)
                RUN: begin
                    if (div_zero) begin
                        result <= '1;
                        rem    <= a_back;
                        dbz    <= 1'b1;
                        ready  <= 1'b1;
                    end else begin
                        part_rem <= keep ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                        dq       <= {dq[WIDTH-2:0], keep};
                        count    <= count + CW'(1);
                    end
                end
                FIX: begin
                    result <= quot_fix;
                    rem    <= rem_fix;
                    ready  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
